// File: rtl/mcm_sched_pkg.sv
// Shared types and constants for the MCM tap scheduler.
package mcm_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam int unsigned NUM_TAPS     = 4;
   localparam int unsigned NUM_PRODUCTS = 12;
   // 14*255 = 3570 and -5*255 = -1275 both fit a 13-bit signed product
   localparam int unsigned PROD_W       = 13;
   localparam logic [3:0]  SEL_ZERO     = 4'd15;

   // Product indices of the MCM_3 output bus
   localparam int unsigned P_NEG2X  = 0;
   localparam int unsigned P_NEG4X  = 1;
   localparam int unsigned P_NEG5X  = 2;
   localparam int unsigned P_NEG3X  = 3;
   localparam int unsigned P_NEG1X  = 4;
   localparam int unsigned P_POS2X  = 5;
   localparam int unsigned P_POS4X  = 6;
   localparam int unsigned P_POS6X  = 7;
   localparam int unsigned P_POS8X  = 8;
   localparam int unsigned P_POS10X = 9;
   localparam int unsigned P_POS12X = 10;
   localparam int unsigned P_POS14X = 11;

endpackage

// File: rtl/mcm_tap_scheduler_mcm3.sv
// MCM_3: shift-add multiple-constant multiplier producing the 12 filter products of x.
module mcm_tap_scheduler_mcm3
   import mcm_sched_pkg::*;
(
   input  logic [7:0]                             x,
   output logic [NUM_PRODUCTS-1:0][PROD_W-1:0]    y
);

   logic [PROD_W-1:0] x1, x2, x3, x4, x5, x8, x16;

   // Shared partial sums, then the signed products in two's complement
   always_comb begin
      x1  = PROD_W'(x);
      x2  = x1 << 1;
      x3  = x2 + x1;
      x4  = x1 << 2;
      x5  = x4 + x1;
      x8  = x1 << 3;
      x16 = x1 << 4;

      y[P_NEG2X]  = PROD_W'(0) - x2;
      y[P_NEG4X]  = PROD_W'(0) - x4;
      y[P_NEG5X]  = PROD_W'(0) - x5;
      y[P_NEG3X]  = PROD_W'(0) - x3;
      y[P_NEG1X]  = PROD_W'(0) - x1;
      y[P_POS2X]  = x2;
      y[P_POS4X]  = x4;
      y[P_POS6X]  = x3 << 1;
      y[P_POS8X]  = x8;
      y[P_POS10X] = x5 << 1;
      y[P_POS12X] = x3 << 2;
      y[P_POS14X] = x16 - x2;
   end

endmodule

// File: rtl/mcm_tap_scheduler.sv
// Time-multiplexes one MCM_3 over four interpolation taps and emits a rounded, clipped sample.
module mcm_tap_scheduler
   import mcm_sched_pkg::*;
#(
   parameter int unsigned SHIFT   = 4,
   parameter int unsigned ACC_W   = 18,
   parameter int unsigned PHASES  = 16,
   parameter int unsigned PHASE_W = 4
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_ref,
   input  logic [PHASE_W-1:0] in_phase,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         out_pel,
   input  logic               cfg_we,
   input  logic [PHASE_W-1:0] cfg_phase,
   input  logic [1:0]         cfg_tap,
   input  logic [3:0]         cfg_sel
);

   localparam logic [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);

   state_t                          state;
   logic [1:0]                      k;
   logic [7:0]                      ref_q   [NUM_TAPS];
   logic [3:0]                      snap_q  [NUM_TAPS];
   logic [3:0]                      sel_tab [PHASES][NUM_TAPS];
   logic signed [ACC_W-1:0]         acc;

   logic [7:0]                          x_c;
   logic [NUM_PRODUCTS-1:0][PROD_W-1:0] y_c;
   logic [3:0]                          sel_c;
   logic [PROD_W-1:0]                   prod_raw_c;
   logic signed [ACC_W-1:0]             prod_c;
   logic signed [ACC_W-1:0]             acc_sum_c;
   logic signed [ACC_W-1:0]             rnd_c;
   logic signed [ACC_W-1:0]             shf_c;
   logic [7:0]                          pel_c;

   mcm_tap_scheduler_mcm3 u_mcm3 (
      .x (x_c),
      .y (y_c)
   );

   // Sample mux, product select, accumulate and round/clip of the running sum
   always_comb begin
      x_c        = ref_q[k];
      sel_c      = snap_q[k];
      prod_raw_c = '0;
      if (sel_c < 4'(NUM_PRODUCTS)) begin
         prod_raw_c = y_c[sel_c];
      end
      prod_c    = $signed({{(ACC_W-PROD_W){prod_raw_c[PROD_W-1]}}, prod_raw_c});
      acc_sum_c = acc + prod_c;
      rnd_c     = acc_sum_c + $signed(RND);
      shf_c     = rnd_c >>> SHIFT;
      if (shf_c[ACC_W-1]) begin
         pel_c = 8'd0;
      end else if (|shf_c[ACC_W-2:8]) begin
         pel_c = 8'd255;
      end else begin
         pel_c = shf_c[7:0];
      end
   end

   // Phase/tap select table; writes land at the edge so a same-cycle accept sees the old entry
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int p = 0; p < int'(PHASES); p++) begin
            for (int t = 0; t < int'(NUM_TAPS); t++) begin
               sel_tab[p][t] <= SEL_ZERO;
            end
         end
      end else if (cfg_we) begin
         sel_tab[cfg_phase][cfg_tap] <= cfg_sel;
      end
   end

   // Request FSM: capture and snapshot, four tap cycles, then hold the result until taken
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_pel   <= 8'd0;
         acc       <= '0;
         k         <= 2'd0;
         for (int t = 0; t < int'(NUM_TAPS); t++) begin
            ref_q[t]  <= 8'd0;
            snap_q[t] <= SEL_ZERO;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  for (int t = 0; t < int'(NUM_TAPS); t++) begin
                     ref_q[t]  <= in_ref[8*t +: 8];
                     snap_q[t] <= sel_tab[in_phase][t];
                  end
                  acc      <= '0;
                  k        <= 2'd0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               acc <= acc_sum_c;
               k   <= k + 2'd1;
               if (k == 2'd3) begin
                  out_pel   <= pel_c;
                  out_valid <= 1'b1;
                  state     <= OUT;
               end
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
